mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port between the processor core (instruction fetch, load/store) and a host loader/debug port.
- Host uses it for program download and memory inspection.
- Round-robin arbitration, one transaction per cycle. Host can lock the port for atomic bursts, with a lock timeout guarding against core starvation.
- Sits between the core/host request buses and the memory macro (synchronous read, 1-cycle latency).

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Round-robin arbiter sharing one memory port between core and host,
//            with host lock and lock timeout.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 16,
   parameter int LOCK_MAX = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   input  logic          h_lock,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          lock_err,
   input  logic          err_clr
);

   localparam logic [1:0]  c_ST_ARB       = 2'd0;
   localparam logic [1:0]  c_ST_LOCKED    = 2'd1;
   localparam logic [1:0]  c_ST_LOCK_WAIT = 2'd2;
   localparam logic        c_PRIO_CORE    = 1'b0;
   localparam logic        c_PRIO_HOST    = 1'b1;
   localparam logic [15:0] c_LOCK_MAX     = 16'(LOCK_MAX);
   localparam logic [15:0] c_CNT_SAT      = 16'hFFFF;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic        r_prio;
   logic        w_prio_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        r_lock_err;
   logic        w_lock_err_nxt;
   logic        w_timeout;
   logic        r_c_rvalid;
   logic        r_h_rvalid;
   logic        w_c_gnt;
   logic        w_h_gnt;

   // Grants are held low while reset is asserted, independent of the clock.
   always_comb begin
      w_c_gnt = 1'b0;
      w_h_gnt = 1'b0;
      if (rst_n) begin
         if (r_state == c_ST_LOCKED) begin
            w_h_gnt = h_req;
         end else if (c_req && h_req) begin
            if (r_prio == c_PRIO_CORE) w_c_gnt = 1'b1;
            else                       w_h_gnt = 1'b1;
         end else begin
            w_c_gnt = c_req;
            w_h_gnt = h_req;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (w_c_gnt) begin
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
         mem_we    = c_we;
      end else if (w_h_gnt) begin
         mem_addr  = h_addr;
         mem_wdata = h_wdata;
         mem_we    = h_we;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      w_cnt_nxt   = r_cnt;
      w_timeout   = 1'b0;
      case (r_state)
         c_ST_LOCKED: begin
            w_prio_nxt = c_PRIO_CORE;
            w_cnt_nxt  = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + 16'd1;
            if (!h_lock) begin
               w_state_nxt = c_ST_ARB;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= c_LOCK_MAX) begin
               w_state_nxt = c_ST_LOCK_WAIT;
               w_timeout   = 1'b1;
            end
         end
         c_ST_LOCK_WAIT: begin
            if (w_c_gnt)      w_prio_nxt = c_PRIO_HOST;
            else if (w_h_gnt) w_prio_nxt = c_PRIO_CORE;
            if (!h_lock) begin
               w_state_nxt = c_ST_ARB;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            // Also recovers the unused encoding back to ARB.
            w_state_nxt = c_ST_ARB;
            if (w_c_gnt)      w_prio_nxt = c_PRIO_HOST;
            else if (w_h_gnt) w_prio_nxt = c_PRIO_CORE;
            if (w_h_gnt && h_lock) begin
               w_state_nxt = c_ST_LOCKED;
               w_cnt_nxt   = 16'd1;
            end
         end
      endcase
   end

   always_comb begin
      w_lock_err_nxt = r_lock_err;
      if (w_timeout)    w_lock_err_nxt = 1'b1;
      else if (err_clr) w_lock_err_nxt = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= c_ST_ARB;
         r_prio     <= c_PRIO_CORE;
         r_cnt      <= '0;
         r_lock_err <= 1'b0;
         r_c_rvalid <= 1'b0;
         r_h_rvalid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prio     <= w_prio_nxt;
         r_cnt      <= w_cnt_nxt;
         r_lock_err <= w_lock_err_nxt;
         r_c_rvalid <= w_c_gnt & ~c_we;
         r_h_rvalid <= w_h_gnt & ~h_we;
      end
   end

   // The macro output register supplies the data; the valid flags align with it.
   assign rdata    = (r_c_rvalid | r_h_rvalid) ? mem_rdata : '0;
   assign c_gnt    = w_c_gnt;
   assign h_gnt    = w_h_gnt;
   assign c_rvalid = r_c_rvalid;
   assign h_rvalid = r_h_rvalid;
   assign lock_err = r_lock_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Function : Directed vector bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c_req, c_we, h_req, h_we, h_lock, err_clr;
   logic [15:0] c_addr, c_wdata, h_addr, h_wdata;
   logic [15:0] mem_rdata;

   logic        c_gnt, c_rvalid, h_gnt, h_rvalid, mem_we, lock_err;
   logic [15:0] rdata, mem_addr, mem_wdata;
   logic        c_gnt4, c_rvalid4, h_gnt4, h_rvalid4, mem_we4, lock_err4;
   logic [15:0] rdata4, mem_addr4, mem_wdata4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        c_req, c_we;
      logic [15:0] c_addr, c_wdata;
      logic        h_req, h_we;
      logic [15:0] h_addr, h_wdata;
      logic        h_lock, err_clr;
      logic        e_cg, e_hg, e_we;
      logic [15:0] e_addr, e_wdata;
      logic        e_crv, e_hrv;
      logic [15:0] e_rdata;
      logic        e_err;
   } vec_t;

   vec_t vq[$];

   mem_port_arbiter #(.AW(16), .DW(16), .LOCK_MAX(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .lock_err(lock_err), .err_clr(err_clr)
   );

   mem_port_arbiter #(.AW(16), .DW(16), .LOCK_MAX(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt4), .c_rvalid(c_rvalid4),
      .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
      .h_lock(h_lock), .h_gnt(h_gnt4), .h_rvalid(h_rvalid4),
      .rdata(rdata4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_we(mem_we4),
      .mem_rdata(mem_rdata), .lock_err(lock_err4), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory model; unwritten words read as A000 | addr.
   logic [15:0]  mem [0:255];
   logic [255:0] wr_flag;
   always @(posedge clk) begin
      if (!rst_n) begin
         wr_flag <= '0;
      end else if (mem_we) begin
         mem[mem_addr[7:0]]     <= mem_wdata;
         wr_flag[mem_addr[7:0]] <= 1'b1;
      end
      mem_rdata <= wr_flag[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (16'hA000 | {8'h00, mem_addr[7:0]});
   end

   function automatic vec_t mk(
      input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
      input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
      input logic hl, input logic ec,
      input logic ecg, input logic ehg, input logic ewe, input logic [15:0] eaddr,
      input logic [15:0] ewd, input logic ecrv, input logic ehrv, input logic [15:0] erd,
      input logic eerr);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
      v.h_req = hr; v.h_we = hw; v.h_addr = ha; v.h_wdata = hd;
      v.h_lock = hl; v.err_clr = ec;
      v.e_cg = ecg; v.e_hg = ehg; v.e_we = ewe; v.e_addr = eaddr; v.e_wdata = ewd;
      v.e_crv = ecrv; v.e_hrv = ehrv; v.e_rdata = erd; v.e_err = eerr;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
      h_req = v.h_req; h_we = v.h_we; h_addr = v.h_addr; h_wdata = v.h_wdata;
      h_lock = v.h_lock; err_clr = v.err_clr;
   endtask

   task automatic chk1(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic chk16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [15:0] ha;
      logic [15:0] hd;

      // Contention: alternate C,H,... with rvalid one cycle after each read grant.
      for (int i = 0; i < 6; i++) begin
         vq.push_back(mk(1,0,16'h0010,16'h0,  1,0,16'h0020,16'h0, 0,0,
                         (i % 2) == 0, (i % 2) == 1, 0,
                         ((i % 2) == 0) ? 16'h0010 : 16'h0020, 16'h0,
                         (i > 0) && ((i % 2) == 1), (i > 0) && ((i % 2) == 0),
                         ((i % 2) == 1) ? 16'hA010 : 16'hA020, 0));
      end
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,1,16'hA020, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
      // Core write then read back.
      vq.push_back(mk(1,1,16'h0010,16'hBEEF, 0,0,16'h0,16'h0, 0,0, 1,0,1,16'h0010,16'hBEEF, 0,0,16'h0, 0));
      vq.push_back(mk(1,0,16'h0010,16'h0, 0,0,16'h0,16'h0, 0,0, 1,0,0,16'h0010,16'h0, 0,0,16'h0, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 1,0,16'hBEEF, 0));
      // Host alone, first with prio=host then with prio=core: no bubbles.
      vq.push_back(mk(0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 0,0, 0,1,0,16'h0020,16'h0, 0,0,16'h0, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 0,0, 0,1,0,16'h0020,16'h0, 0,1,16'hA020, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 1,0,16'h0020,16'h0, 0,0, 0,1,0,16'h0020,16'h0, 0,1,16'hA020, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,1,16'hA020, 0));
      // Locked burst of 10 host writes; core request blocked after the first.
      for (int i = 0; i < 10; i++) begin
         ha = 16'h0030 + 16'(i);
         hd = 16'h5000 + 16'(i);
         vq.push_back(mk(i > 0,0,16'h0010,16'h0, 1,1,ha,hd, 1,0, 0,1,1,ha,hd, 0,0,16'h0, 0));
      end
      vq.push_back(mk(1,0,16'h0010,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
      vq.push_back(mk(1,0,16'h0010,16'h0, 0,0,16'h0,16'h0, 0,0, 1,0,0,16'h0010,16'h0, 0,0,16'h0, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 1,0,16'hBEEF, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 1,0,16'h0039,16'h0, 0,0, 0,1,0,16'h0039,16'h0, 0,0,16'h0, 0));
      vq.push_back(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,1,16'h5009, 0));

      // Reset with both requesting.
      rst_n = 1'b0;
      drive(mk(1,0,16'h0010,16'h0, 1,0,16'h0020,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
      #2;
      chk1("rst_c_gnt", 0, c_gnt, 1'b0);
      chk1("rst_h_gnt", 0, h_gnt, 1'b0);
      chk1("rst_mem_we", 0, mem_we, 1'b0);
      chk16("rst_mem_addr", 0, mem_addr, 16'h0);
      chk1("rst_lock_err", 0, lock_err, 1'b0);
      repeat (3) @(negedge clk);
      chk1("rst_c_rvalid", 1, c_rvalid, 1'b0);
      chk1("rst_h_rvalid", 1, h_rvalid, 1'b0);
      chk16("rst_rdata", 1, rdata, 16'h0);
      chk1("rst_c_gnt", 1, c_gnt, 1'b0);
      chk1("rst_h_gnt", 1, h_gnt, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         if (i > 0) @(negedge clk);
         v = vq[i];
         drive(v);
         #2;
         chk1("c_gnt", i, c_gnt, v.e_cg);
         chk1("h_gnt", i, h_gnt, v.e_hg);
         chk1("mem_we", i, mem_we, v.e_we);
         chk16("mem_addr", i, mem_addr, v.e_addr);
         chk16("mem_wdata", i, mem_wdata, v.e_wdata);
         chk1("c_rvalid", i, c_rvalid, v.e_crv);
         chk1("h_rvalid", i, h_rvalid, v.e_hrv);
         chk1("lock_err", i, lock_err, v.e_err);
         if (v.e_crv || v.e_hrv) chk16("rdata", i, rdata, v.e_rdata);
      end

      // Reset while a read is in flight drops the pending rvalid.
      @(negedge clk);
      drive(mk(1,0,16'h0020,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
      #2;
      chk1("midrd_c_gnt", 0, c_gnt, 1'b1);
      @(negedge clk);
      drive(mk(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
      #1;
      chk1("midrd_c_rvalid_before", 1, c_rvalid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midrd_c_rvalid_after", 2, c_rvalid, 1'b0);
      chk16("midrd_rdata", 2, rdata, 16'h0);
      repeat (2) @(negedge clk);

      // Lock timeout on the LOCK_MAX=4 instance: lock, 4 locked cycles, then alternate.
      rst_n = 1'b1;
      for (int s = 0; s <= 10; s++) begin
         logic ec, eh, ee;
         if (s > 0) @(negedge clk);
         drive(mk(s > 0,0,16'h0010,16'h0, 1,0,16'h0020,16'h0, 1, s == 9,
                  0,0,0,16'h0,16'h0, 0,0,16'h0, 0));
         ec = (s == 5) || (s == 7) || (s == 9);
         eh = !ec;
         ee = (s >= 5) && (s <= 9);
         #2;
         chk1("to_c_gnt", s, c_gnt4, ec);
         chk1("to_h_gnt", s, h_gnt4, eh);
         chk1("to_lock_err", s, lock_err4, ee);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
